// File: rtl/winreg_pkg.sv
// Shared defaults, width helpers and the stack entry type for the windowed register file.
package winreg_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_PHYS_REGS   = 32;
    localparam int DEF_WIN_SIZE    = 8;
    localparam int DEF_STACK_DEPTH = 8;

    function automatic int addr_w(input int win_size);
        return (win_size > 1) ? $clog2(win_size) : 1;
    endfunction

    function automatic int fp_w(input int phys_regs);
        return (phys_regs > 1) ? $clog2(phys_regs) : 1;
    endfunction

    function automatic int depth_w(input int stack_depth);
        return $clog2(stack_depth + 1);
    endfunction

    localparam int DEF_ADDR_W = addr_w(DEF_WIN_SIZE);

    // One saved slide amount; wide enough to hold 0..WIN_SIZE
    typedef logic [DEF_ADDR_W:0] shift_t;

endpackage

// File: rtl/windowed_regfile_if.sv
// Port bundle for windowed_regfile: window-relative read/write ports, call/return strobes, status.
interface windowed_regfile_if
    import winreg_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PHYS_REGS   = DEF_PHYS_REGS,
    parameter int WIN_SIZE    = DEF_WIN_SIZE,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
);
    localparam int ADDR_W  = addr_w(WIN_SIZE);
    localparam int FP_W    = fp_w(PHYS_REGS);
    localparam int DEPTH_W = depth_w(STACK_DEPTH);

    logic [ADDR_W-1:0]          Rd_Addr, Rs_Addr, Rm_Addr;
    logic                       Rd_Wen, Rs_Wen;
    logic [DATA_W-1:0]          Rd_Data, Rs_Data;
    logic                       Call;
    logic [ADDR_W:0]            Call_Shift;
    logic                       Rtn;
    logic                       Clear_Err;
    logic [DATA_W-1:0]          Rd_Out, Rs_Out, Rm_Out;
    logic [WIN_SIZE*DATA_W-1:0] Window_Out;
    logic [FP_W-1:0]            FP_Out;
    logic [DEPTH_W-1:0]         Depth;
    logic                       Overflow, Underflow;

    modport master (
        output Rd_Addr, Rs_Addr, Rm_Addr, Rd_Wen, Rs_Wen, Rd_Data, Rs_Data,
               Call, Call_Shift, Rtn, Clear_Err,
        input  Rd_Out, Rs_Out, Rm_Out, Window_Out, FP_Out, Depth, Overflow, Underflow
    );

    modport slave (
        input  Rd_Addr, Rs_Addr, Rm_Addr, Rd_Wen, Rs_Wen, Rd_Data, Rs_Data,
               Call, Call_Shift, Rtn, Clear_Err,
        output Rd_Out, Rs_Out, Rm_Out, Window_Out, FP_Out, Depth, Overflow, Underflow
    );

endinterface

// File: rtl/winreg_fp_stack.sv
// LIFO of saved window slide amounts; the caller guarantees push and pop are never both high.
module winreg_fp_stack
    import winreg_pkg::*;
#(
    parameter int DEPTH   = DEF_STACK_DEPTH,
    parameter int ENTRY_W = DEF_ADDR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [ENTRY_W-1:0]          push_data_i,
    output logic [ENTRY_W-1:0]          top_o,
    output logic [depth_w(DEPTH)-1:0]   depth_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int CNT_W = depth_w(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] stk_q [DEPTH];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr, top_ptr;
    logic               do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign depth_o = cnt_q;

    assign wr_ptr  = PTR_W'(cnt_q);
    assign top_ptr = PTR_W'(cnt_q - CNT_W'(1));
    assign top_o   = stk_q[top_ptr];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push)     cnt_d = cnt_q + CNT_W'(1);
        else if (do_pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) stk_q[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/windowed_regfile.sv
// Sliding-window register file: PHYS_REGS registers seen through a WIN_SIZE window at FP.
// Optional macro WINREG_BYPASS_EN forwards same-cycle write data to the read ports and Window_Out.
module windowed_regfile
    import winreg_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PHYS_REGS   = DEF_PHYS_REGS,
    parameter int WIN_SIZE    = DEF_WIN_SIZE,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic               Clock,
    input  logic               Reset_n,
    windowed_regfile_if.slave  bus
);
    localparam int ADDR_W  = addr_w(WIN_SIZE);
    localparam int FP_W    = fp_w(PHYS_REGS);
    localparam int DEPTH_W = depth_w(STACK_DEPTH);
    localparam int FP_MAX  = PHYS_REGS - WIN_SIZE;

    logic [DATA_W-1:0]  regs_q [PHYS_REGS];
    logic [DATA_W-1:0]  regs_d [PHYS_REGS];
    logic [FP_W-1:0]    fp_q, fp_d;
    logic               ov_q, ov_d;
    logic               un_q, un_d;

    logic [FP_W-1:0]    rd_pa, rs_pa, rm_pa;
    logic [FP_W:0]      call_sum;
    logic               do_call, do_rtn, call_ok, push, pop;
    logic [ADDR_W:0]    stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full, stk_empty;

    // FP never exceeds FP_MAX, so these sums stay inside the physical array
    assign rd_pa = fp_q + FP_W'(bus.Rd_Addr);
    assign rs_pa = fp_q + FP_W'(bus.Rs_Addr);
    assign rm_pa = fp_q + FP_W'(bus.Rm_Addr);

    // Call and Rtn together cancel each other out entirely
    assign do_call  = bus.Call && !bus.Rtn;
    assign do_rtn   = bus.Rtn && !bus.Call;
    assign call_sum = {1'b0, fp_q} + (FP_W+1)'(bus.Call_Shift);
    assign call_ok  = !stk_full && (call_sum <= (FP_W+1)'(FP_MAX));
    assign push     = do_call && call_ok;
    assign pop      = do_rtn && !stk_empty;

    winreg_fp_stack #(
        .DEPTH   (STACK_DEPTH),
        .ENTRY_W (ADDR_W + 1)
    ) u_stack (
        .clk         (Clock),
        .rst_n       (Reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (bus.Call_Shift),
        .top_o       (stk_top),
        .depth_o     (stk_depth),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_comb begin
        fp_d = fp_q;
        if (push)     fp_d = fp_q + FP_W'(bus.Call_Shift);
        else if (pop) fp_d = fp_q - FP_W'(stk_top);
    end

    // A new error in the same cycle as Clear_Err keeps the flag set
    always_comb begin
        ov_d = bus.Clear_Err ? 1'b0 : ov_q;
        un_d = bus.Clear_Err ? 1'b0 : un_q;
        if (do_call && !call_ok)   ov_d = 1'b1;
        if (do_rtn && stk_empty)   un_d = 1'b1;
    end

    // Rd is applied last so it wins a same-address collision with Rs
    always_comb begin
        regs_d = regs_q;
        if (bus.Rs_Wen) regs_d[rs_pa] = bus.Rs_Data;
        if (bus.Rd_Wen) regs_d[rd_pa] = bus.Rd_Data;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fp_q <= '0;
            ov_q <= 1'b0;
            un_q <= 1'b0;
            for (int i = 0; i < PHYS_REGS; i++) regs_q[i] <= '0;
        end else begin
            fp_q   <= fp_d;
            ov_q   <= ov_d;
            un_q   <= un_d;
            regs_q <= regs_d;
        end
    end

`ifdef WINREG_BYPASS_EN
    function automatic logic [DATA_W-1:0] rd_fwd(input logic [FP_W-1:0] pa);
        if (bus.Rd_Wen && (rd_pa == pa)) return bus.Rd_Data;
        if (bus.Rs_Wen && (rs_pa == pa)) return bus.Rs_Data;
        return regs_q[pa];
    endfunction

    assign bus.Rd_Out = rd_fwd(rd_pa);
    assign bus.Rs_Out = rd_fwd(rs_pa);
    assign bus.Rm_Out = rd_fwd(rm_pa);
`else
    assign bus.Rd_Out = regs_q[rd_pa];
    assign bus.Rs_Out = regs_q[rs_pa];
    assign bus.Rm_Out = regs_q[rm_pa];
`endif

    for (genvar i = 0; i < WIN_SIZE; i++) begin : g_win
        logic [FP_W-1:0] win_pa;
        assign win_pa = fp_q + FP_W'(i);
`ifdef WINREG_BYPASS_EN
        assign bus.Window_Out[i*DATA_W +: DATA_W] = rd_fwd(win_pa);
`else
        assign bus.Window_Out[i*DATA_W +: DATA_W] = regs_q[win_pa];
`endif
    end

    assign bus.FP_Out    = fp_q;
    assign bus.Depth     = stk_depth;
    assign bus.Overflow  = ov_q;
    assign bus.Underflow = un_q;

endmodule

// File: doc/windowed_regfile.md
# windowed_regfile

Parametrised sliding-window register file for the CPU datapath, the successor to the fixed 16-entry/8-window register block. It holds PHYS_REGS physical registers and exposes a WIN_SIZE-register window at a frame pointer (FP). CALL slides the window up by a per-call amount, and RTN restores it from an internal shift stack. The block also provides three read ports, two write ports, sticky overflow/underflow flags and the full window as a flat bus for debug and the display path.

## Interface
- DATA_W, 16, register width
- PHYS_REGS, 32, physical register count (power of two, > WIN_SIZE)
- WIN_SIZE, 8, window size (power of two); ADDR_W = $clog2(WIN_SIZE), FP_W = $clog2(PHYS_REGS)
- STACK_DEPTH, 8, maximum nested calls
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Rd_Addr, Rs_Addr, Rm_Addr  in  ADDR_W  window-relative addresses
- Rd_Wen, Rs_Wen  in  1  write enables
- Rd_Data, Rs_Data  in  DATA_W  write data
- Call  in  1  push Call_Shift and slide the window up
- Call_Shift  in  ADDR_W+1  slide amount, 0..WIN_SIZE
- Rtn  in  1  pop and slide the window down
- Clear_Err  in  1  clear the sticky flags
- Rd_Out, Rs_Out, Rm_Out  out  DATA_W  combinational reads at the current FP
- Window_Out  out  WIN_SIZE*DATA_W  entry i at [i*DATA_W +: DATA_W]
- FP_Out  out  FP_W  current frame pointer
- Depth  out  $clog2(STACK_DEPTH+1)  stack occupancy
- Overflow, Underflow  out  1  sticky error flags

## Operation
- Physical address = FP + window address, computed FP_W bits wide. FP is always kept ≤ PHYS_REGS−WIN_SIZE, so the sum never wraps.
- Writes resolve against the FP held before the edge, including in Call and Rtn cycles.
- If Rd and Rs target the same address in one cycle, Rd wins.
- Call accepted: requires Depth < STACK_DEPTH and FP+Call_Shift ≤ PHYS_REGS−WIN_SIZE. Action: push Call_Shift, FP += Call_Shift, Depth++. Call_Shift=0 is legal; it pushes 0 and leaves FP unchanged.
- Call rejected: FP, stack and Depth are unchanged and Overflow is set. Writes in that cycle still occur.
- Rtn with Depth > 0: pop the top shift, FP −= popped value, Depth−−.
- Rtn with Depth = 0: FP is unchanged and Underflow is set.
- Call and Rtn asserted together: both are ignored and no flag changes. Writes still occur.
- Clear_Err clears both flags. If an error occurs in the same cycle, the set wins.
- Reset: all physical registers, FP, stack and Depth are cleared to 0. Overflow and Underflow are cleared to 0.
- Reset values of outputs: Rd_Out, Rs_Out, Rm_Out and Window_Out read 0 because the registers are cleared. FP_Out=0, Depth=0, Overflow=0, Underflow=0.

## Timing
- Read ports, Window_Out and FP_Out are combinational from the current state, with zero latency.
- Writes, FP changes, stack changes and flag changes take effect at the rising edge.
- After a Call or Rtn, the new window is visible the cycle after the edge. The stack top is visible to Rtn in the cycle after a Call, so back-to-back Call→Rtn restores FP in 2 cycles.
- Reset asserted mid-sequence clears state immediately, with no dependence on Clock. The first Call or Rtn is accepted at the first rising edge after deassertion.
- No handshake. Call and Rtn are single-cycle strobes and are sampled every cycle they are high.

## Configuration
- WINREG_BYPASS_EN defined: a read port whose address matches an enabled write in the same cycle returns that write's data combinationally. When both Rd and Rs writes match, Rd data is forwarded. Window_Out is bypassed the same way.
- WINREG_BYPASS_EN undefined: reads return the pre-edge register contents. Written data is visible from the next cycle.

## Structure
- The package winreg_pkg holds:
  - default parameter values;
  - ADDR_W/FP_W derivation functions;
  - a typedef for stack entries (ADDR_W+1 bits).
- Sub-module winreg_fp_stack is a LIFO of STACK_DEPTH shift entries.
  - Inputs: push, pop, push data.
  - Outputs: top, depth, full, empty.
  - Reset: asynchronous, active-low.
- The top level owns the register array, the FP arithmetic, the flags and the optional bypass.

## Test plan
- Reset, then write Rd_Addr=3 with 0xBEEF. Next cycle Rm_Addr=3 → Rm_Out=0xBEEF and Window_Out entry 3 = 0xBEEF. With WINREG_BYPASS_EN the value appears in the write cycle; without it, 0 in the write cycle.
- Call with shift 4, FP 0→4. Read address 0 → physical 4. A prior write at window address 4 (old FP) is now visible at address 0. Then Rtn → FP_Out=0, Depth=0.
- Nested Calls 8,8,8 with PHYS_REGS=32 → FP=24. A 4th Call with shift 1 → Overflow=1, FP stays 24, Depth=3.
- Rtn at Depth=0 → Underflow=1 and FP unchanged. Clear_Err → both flags 0 next cycle.
- Call and Rtn high together at FP=4, Depth=1 → no change. Same-cycle Rd and Rs writes to address 2 (0x1111, 0x2222) → 0x1111 stored.
- Reset_n pulsed low mid-cycle after three Calls → FP_Out, Depth, flags and all registers read 0 without waiting for a clock edge.
